// File: rtl/wb_data_slave.sv
// Wishbone data-bus slave: shared RAM, test-and-set locks and a free-running
// 32-bit cycle counter behind a one-at-a-time, wait-stated handshake.
module wb_data_slave #(
    parameter int unsigned   DW       = 16,
    parameter int unsigned   RAM_AW   = 10,
    parameter int unsigned   WAIT     = 1,
    parameter logic [DW-1:0] IO_BASE  = 16'hFF00,
    parameter int unsigned   NUM_LOCK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_cyc,
    input  logic                wb_stb,
    input  logic                wb_we,
    input  logic [DW-1:0]       wb_adr,
    input  logic [DW-1:0]       wb_dat_i,
    output logic [DW-1:0]       wb_dat_o,
    output logic                wb_ack,
    output logic [NUM_LOCK-1:0] lock_state
);

    localparam logic [2:0] WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAITS, ACK, RECOVER} state_e;

    state_e                state_q, state_d;
    logic [DW-1:0]         adr_q, adr_d;
    logic                  we_q, we_d;
    logic [DW-1:0]         dat_q, dat_d;
    logic [2:0]            wait_q, wait_d;
    logic [NUM_LOCK-1:0]   lock_q, lock_d;
    logic [31:0]           cnt_q;
    logic [15:0]           hi_q, hi_d;
    logic [DW-1:0]         mem [2**RAM_AW];

    logic                  ram_hit, io_hit, cnt_lo_hit, cnt_hi_hit;
    logic [7:0]            io_off;
    logic [NUM_LOCK-1:0]   lock_sel;
    logic [DW-1:0]         rdata;
    logic                  in_ack;

    assign in_ack = (state_q == ACK);

    // Address decode works on the registered request so it is stable in ACK.
    always_comb begin
        ram_hit    = (adr_q[DW-1:RAM_AW] == '0);
        io_hit     = (adr_q[DW-1:8] == IO_BASE[DW-1:8]);
        io_off     = adr_q[7:0] - IO_BASE[7:0];
        cnt_lo_hit = io_hit && (io_off == 8'hF0);
        cnt_hi_hit = io_hit && (io_off == 8'hF1);
        for (int k = 0; k < NUM_LOCK; k++) begin
            lock_sel[k] = io_hit && (io_off == 8'(k));
        end
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = mem[adr_q[RAM_AW-1:0]];
        end else if (|lock_sel) begin
            rdata = {{(DW-1){1'b0}}, ~|(lock_sel & lock_q)};
        end else if (cnt_lo_hit) begin
            rdata = DW'(cnt_q[15:0]);
        end else if (cnt_hi_hit) begin
            rdata = DW'(hi_q);
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        we_d    = we_q;
        dat_d   = dat_q;
        wait_d  = wait_q;
        lock_d  = lock_q;
        hi_d    = hi_q;
        unique case (state_q)
            IDLE: begin
                if (wb_cyc && wb_stb) begin
                    adr_d = wb_adr;
                    we_d  = wb_we;
                    dat_d = wb_dat_i;
                    if (WAIT == 0) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAITS;
                        wait_d  = WAIT_LOAD;
                    end
                end
            end
            WAITS: begin
                if (!wb_cyc) begin
                    state_d = IDLE;
                end else if (wait_q == 3'd0) begin
                    state_d = ACK;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ACK: begin
                state_d = RECOVER;
                if (!we_q) begin
                    lock_d = lock_q | lock_sel;
                    if (cnt_lo_hit) begin
                        hi_d = cnt_q[31:16];
                    end
                end else if (!dat_q[0]) begin
                    lock_d = lock_q & ~lock_sel;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            wait_q  <= '0;
            lock_q  <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            dat_q   <= dat_d;
            wait_q  <= wait_d;
            lock_q  <= lock_d;
            cnt_q   <= cnt_q + 32'd1;
            hi_q    <= hi_d;
        end
    end

    // NOTE: the RAM array has no reset; software must write before it reads.
    always_ff @(posedge clk) begin
        if (in_ack && we_q && ram_hit) begin
            mem[adr_q[RAM_AW-1:0]] <= dat_q;
        end
    end

    assign wb_ack     = in_ack;
    assign wb_dat_o   = (in_ack && !we_q) ? rdata : '0;
    assign lock_state = lock_q;

endmodule

// File: tb/tb_wb_data_slave.sv
// Randomized scoreboard bench for wb_data_slave: stimulus pushes expected acks,
// a negedge monitor pops and compares data and ack latency.
module tb_wb_data_slave;

    localparam int          DW       = 16;
    localparam int          RAM_AW   = 10;
    localparam int          WAIT     = 1;
    localparam int          NUM_LOCK = 4;
    localparam logic [15:0] IO_BASE  = 16'hFF00;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                wb_cyc = 1'b0;
    logic                wb_stb = 1'b0;
    logic                wb_we = 1'b0;
    logic [DW-1:0]       wb_adr = '0;
    logic [DW-1:0]       wb_dat_i = '0;
    logic [DW-1:0]       wb_dat_o;
    logic                wb_ack;
    logic [NUM_LOCK-1:0] lock_state;

    wb_data_slave #(
        .DW(DW), .RAM_AW(RAM_AW), .WAIT(WAIT), .IO_BASE(IO_BASE), .NUM_LOCK(NUM_LOCK)
    ) dut (
        .clk(clk), .rst(rst), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
        .lock_state(lock_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]     data;
        bit              chk;
        longint unsigned cyc;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    int              vectors = 0;
    int              miscompares = 0;
    longint unsigned cyc_cnt = 0;

    // Reference model state
    logic [31:0]     cnt_m;
    logic [15:0]     mem_m [int];
    int              written_q[$];
    logic [3:0]      lock_m = '0;
    logic [15:0]     hi_m = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) cnt_m <= '0;
        else      cnt_m <= cnt_m + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst && wb_ack) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_latency", 32'(cyc_cnt), 32'(mon_e.cyc));
                if (mon_e.chk) check("read_data", wb_dat_o, mon_e.data);
            end
        end else if (rst && wb_cyc) begin
            check("dat_o_not_ack", wb_dat_o, 32'd0);
        end
    end

    // Called at posedge+1: drives the request, waits for ack, holds stb through RECOVER.
    task automatic bus(input bit we, input logic [15:0] adr, input logic [15:0] dat,
                       input logic [15:0] exp, input bit chk);
        exp_t e;
        bit   got;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
        e.data = exp; e.chk = chk; e.cyc = cyc_cnt + WAIT + 1;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            got = wb_ack;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL ack_timeout: no ack for adr %h within 16 cycles", adr);
            exp_q.delete();
        end
        @(posedge clk);
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] adr);
        logic [15:0] exp;
        logic [31:0] c;
        int          off;
        exp = '0;
        off = int'(adr) - int'(IO_BASE);
        if (int'(adr) < 2**RAM_AW) begin
            exp = mem_m[int'(adr)];
        end else if (adr >= IO_BASE) begin
            if (off < NUM_LOCK) begin
                exp = lock_m[off] ? 16'h0000 : 16'h0001;
                lock_m[off] = 1'b1;
            end else if (off == 'hF0) begin
                c    = cnt_m + 32'(WAIT + 1);
                exp  = c[15:0];
                hi_m = c[31:16];
            end else if (off == 'hF1) begin
                exp = hi_m;
            end
        end
        bus(1'b0, adr, 16'h0000, exp, 1'b1);
    endtask

    task automatic do_read(input logic [15:0] adr);
        @(posedge clk); #1;
        issue_read(adr);
    endtask

    task automatic do_write(input logic [15:0] adr, input logic [15:0] dat);
        int off;
        @(posedge clk); #1;
        off = int'(adr) - int'(IO_BASE);
        if (int'(adr) < 2**RAM_AW) begin
            if (!mem_m.exists(int'(adr))) written_q.push_back(int'(adr));
            mem_m[int'(adr)] = dat;
        end else if (adr >= IO_BASE && off < NUM_LOCK && !dat[0]) begin
            lock_m[off] = 1'b0;
        end
        bus(1'b1, adr, dat, 16'h0000, 1'b0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        int          r;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ack", wb_ack, 32'd0);
        check("reset_dat", wb_dat_o, 32'd0);
        check("reset_locks", lock_state, 32'd0);
        #2 rst = 1'b1;

        // Write then read back through the wait-stated handshake
        do_write(16'h0010, 16'hA5A5);
        do_read(16'h0010);

        // Test-and-set lock 0
        do_read(IO_BASE);
        do_read(IO_BASE);
        check("lock0_set", lock_state, 32'h1);
        do_write(IO_BASE, 16'h0000);
        check("lock0_clear", lock_state, 32'h0);
        do_read(IO_BASE);

        // Hole access must not alias into RAM
        do_write(16'h0000, 16'h1234);
        do_read(16'h0800);
        do_write(16'h0800, 16'hDEAD);
        do_read(16'h0000);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 7));
            case (r)
                0, 1: do_write(16'($urandom_range(0, 2**RAM_AW - 1)), 16'($urandom));
                2: begin
                    if (written_q.size() > 0)
                        do_read(16'(written_q[$urandom_range(0, written_q.size() - 1)]));
                    else
                        do_read(16'h0400);
                end
                3: do_read(IO_BASE + 16'($urandom_range(0, NUM_LOCK - 1)));
                4: do_write(IO_BASE + 16'($urandom_range(0, NUM_LOCK - 1)), 16'($urandom));
                5: begin
                    a = 16'($urandom_range(2**RAM_AW, 16'hFEFF));
                    if ($urandom_range(0, 1) == 0) do_read(a);
                    else                           do_write(a, 16'($urandom));
                end
                6: begin
                    do_read(IO_BASE + 16'hF0);
                    if ($urandom_range(0, 1) == 0) do_read(IO_BASE + 16'hF1);
                end
                default: begin
                    if ($urandom_range(0, 1) == 0) a = IO_BASE + 16'($urandom_range(NUM_LOCK, 239));
                    else                           a = IO_BASE + 16'($urandom_range(242, 255));
                    d = 16'($urandom);
                    if ($urandom_range(0, 1) == 0) do_read(a);
                    else                           do_write(a, d);
                end
            endcase
            check("lock_model", lock_state, 32'(lock_m));
        end

        // Counter across the 16-bit boundary; high shadow must stay frozen
        repeat (70000) @(posedge clk);
        do_read(IO_BASE + 16'hF0);
        do_read(IO_BASE + 16'hF1);
        check("cnt_hi_nonzero", 32'(hi_m != 16'h0000), 32'd1);
        repeat (50) @(posedge clk);
        do_read(IO_BASE + 16'hF1);

        // Abort during WAITS: no ack, no lock side effect, FSM idle right after
        do_write(IO_BASE + 16'h2, 16'h0000);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = IO_BASE + 16'h2;
        @(posedge clk); #1;
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(posedge clk); #1;
        check("abort_lock", lock_state, 32'(lock_m));
        issue_read(IO_BASE + 16'h2);

        // Asynchronous reset mid-WAITS on a lock read
        do_write(IO_BASE + 16'h1, 16'h0000);
        do_read(IO_BASE + 16'h3);
        @(posedge clk); #1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = IO_BASE + 16'h1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rst_mid_ack", wb_ack, 32'd0);
        check("rst_mid_dat", wb_dat_o, 32'd0);
        check("rst_mid_locks", lock_state, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        lock_m = '0;
        hi_m   = '0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        do_read(IO_BASE + 16'h1);
        do_read(IO_BASE + 16'hF0);
        do_read(16'h0010);

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
